ctrl_pipe_unit: RTL

//  Pipelined control unit for the 16-bit WISC core. It decodes the 4-bit opcode in ID into a
//  10-bit control bundle and carries bundle+dest reg through ID/EX, EX/MEM and MEM/WB.
//  It detects load-use hazards, applies branch flush and global stall, and sequences HLT
//  via a drain FSM. Sits between IF/ID register and datapath stage muxes.

---
 rtl/ctrl_pipe_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes the ID opcode into a control bundle and carries it through
// the EX, MEM and WB stage registers. It also handles load-use hazards, branch flush, global stall and halt drain.
module ctrl_pipe_unit #(
  parameter int REG_AW       = 4,
  parameter bit ZERO_REG_SUP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  input  logic              stall_ext,
  output logic              load_use_stall,
  output logic              halt_pending,
  output logic              halted,
  output logic              ex_valid,
  output logic [9:0]        ex_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic [9:0]        mem_ctrl,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic [9:0]        wb_ctrl,
  output logic [REG_AW-1:0] wb_rd
);

  localparam int C_REGWRITE = 0;
  localparam int C_MEMREAD  = 2;
  localparam int C_HLT      = 9;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [9:0]        dec_ctrl;
  logic              src_match;
  logic              rd_ok;
  logic              issue;
  logic              ex_valid_nxt;
  logic [9:0]        ex_ctrl_nxt;
  logic [REG_AW-1:0] ex_rd_nxt;

  // Bundle order: {hlt,Br,PCStore,LxB,ALUSrc,Branch,MemtoReg,MemRead,MemWrite,RegWrite}
  always_comb begin
    dec_ctrl = 10'h000;
    case (id_opcode)
      4'b0100, 4'b0101, 4'b0110: dec_ctrl = 10'h021;
      4'b1000:                   dec_ctrl = 10'h02D;
      4'b1001:                   dec_ctrl = 10'h022;
      4'b1010, 4'b1011:          dec_ctrl = 10'h061;
      4'b1100:                   dec_ctrl = 10'h030;
      4'b1101:                   dec_ctrl = 10'h130;
      4'b1110:                   dec_ctrl = 10'h081;
      4'b1111:                   dec_ctrl = 10'h200;
      default:                   dec_ctrl = 10'h001;
    endcase
    if (ZERO_REG_SUP && (id_rd == '0)) begin
      dec_ctrl[C_REGWRITE] = 1'b0;
    end
  end

  always_comb begin
    src_match = (ex_rd == id_rs) || (ex_rd == id_rt);
    rd_ok     = !ZERO_REG_SUP || (ex_rd != '0);
    load_use_stall = id_valid && ex_valid && ex_ctrl[C_MEMREAD] && src_match && rd_ok &&
                     !flush && (state == ST_RUN);
  end

  // Flush, load-use and any non-RUN state all turn the ID/EX load into a bubble.
  always_comb begin
    issue        = id_valid && (state == ST_RUN) && !flush && !load_use_stall;
    ex_valid_nxt = issue;
    ex_ctrl_nxt  = issue ? dec_ctrl : 10'h000;
    ex_rd_nxt    = issue ? id_rd : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (!stall_ext && issue && dec_ctrl[C_HLT]) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!stall_ext && mem_valid && mem_ctrl[C_HLT]) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    halt_pending = (state != ST_RUN);
    halted       = (state == ST_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= 10'h000;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= 10'h000;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= 10'h000;
      wb_rd     <= '0;
    end else if (!stall_ext) begin
      ex_valid  <= ex_valid_nxt;
      ex_ctrl   <= ex_ctrl_nxt;
      ex_rd     <= ex_rd_nxt;
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl;
      mem_rd    <= ex_rd;
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl;
      wb_rd     <= mem_rd;
    end
  end

endmodule
